ap3216_i2c_responder: RTL and testbench

I2C target that emulates the AP3216 ambient-light sensor: answers at a 7-bit device address, holds the system-config register, and serves a 16-bit ALS value supplied by the fabric through the ALS data registers. It is the responder counterpart of the AP3216 driver's I2C master. It is used for hardware-in-loop and simulation of the backlight path without a physical sensor, on the same I_clk domain.

---
 rtl/ap3216_pkg.sv | 40 ++++
 rtl/i2c_line_sync.sv | 71 +++++++
 rtl/ap3216_i2c_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_ap3216_i2c_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ap3216_pkg.sv
// rtl/ap3216_pkg.sv - shared constants, state encoding and register read mux for the AP3216 responder
package ap3216_pkg;

    localparam logic [6:0] AP3216_DEV_ADDR = 7'h1E;

    localparam logic [7:0] REG_SYS_CONFIG = 8'h00;
    localparam logic [7:0] REG_ALS_L      = 8'h0C;
    localparam logic [7:0] REG_ALS_H      = 8'h0D;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    // ALS bytes read as zero while the ALS enable bit (SYS_CONFIG[0]) is clear.
    function automatic logic [7:0] reg_read(
        input logic [7:0]  ptr,
        input logic [7:0]  sys_config,
        input logic [15:0] shadow
    );
        logic [7:0] val;
        val = 8'h00;
        case (ptr)
            REG_SYS_CONFIG: val = sys_config;
            REG_ALS_L:      val = sys_config[0] ? shadow[7:0]  : 8'h00;
            REG_ALS_H:      val = sys_config[0] ? shadow[15:8] : 8'h00;
            default:        val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - scl/sda synchronizers with START, STOP and scl edge pulse generation
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic start_pulse,
    output logic stop_pulse,
    output logic scl_rise,
    output logic scl_fall
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d;
    logic sda_prev_q, sda_prev_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Shift the raw lines through the synchronizers and derive bus events from old/new levels.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        start_d    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_d     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        rise_d     = scl_s & ~scl_prev_q;
        fall_d     = ~scl_s & scl_prev_q;
    end

    // Idle bus is high on both lines, so the synchronizers reset to 1 to avoid a spurious edge.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    // sda_prev_q is the level the registered pulses were computed from, keeping sampling aligned.
    assign sda_level   = sda_prev_q;
    assign start_pulse = start_q;
    assign stop_pulse  = stop_q;
    assign scl_rise    = rise_q;
    assign scl_fall    = fall_q;

endmodule

// File: rtl/ap3216_i2c_responder.sv
// rtl/ap3216_i2c_responder.sv - I2C target emulating the AP3216 ambient-light sensor register set
module ap3216_i2c_responder
    import ap3216_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = AP3216_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] I_als_data,
    output logic [7:0]  O_sys_config,
    output logic        O_wr_pulse,
    output logic        O_busy
);

    logic sda_level, start_pulse, stop_pulse, scl_rise, scl_fall;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .I_clk      (I_clk),
        .I_reset    (I_reset),
        .scl_in     (scl),
        .sda_in     (sda),
        .sda_level  (sda_level),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall)
    );

    i2c_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic [15:0] shadow_q, shadow_d;
    logic [7:0]  sys_config_q, sys_config_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic        busy_q, busy_d;

    logic [7:0]  shift_in;
    logic [7:0]  cur_byte;
    logic [7:0]  next_byte;
    logic        byte_done;

    // Next-state, datapath and sda drive decisions; all line activity happens on scl edge pulses.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        rw_d         = rw_q;
        shadow_d     = shadow_q;
        sys_config_d = sys_config_q;
        sda_oe_d     = sda_oe_q;
        wr_pulse_d   = 1'b0;
        busy_d       = busy_q;

        shift_in  = {shift_q[6:0], sda_level};
        cur_byte  = reg_read(ptr_q, sys_config_q, shadow_q);
        next_byte = reg_read(ptr_q + 8'd1, sys_config_q, shadow_q);
        byte_done = scl_fall && (bit_cnt_q == 4'd8);

        if (stop_pulse) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_pulse) begin
            // Repeated START keeps the pointer so a write-pointer/read sequence works.
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            if (shift_q[0]) begin
                                shadow_d = I_als_data;
                            end
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = cur_byte;
                            sda_oe_d = ~cur_byte[7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        ptr_d     = shift_q;
                        state_d   = ST_PTR_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WDATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WDATA_ACK;
                        sda_oe_d  = 1'b1;
                    end
                end
                ST_WDATA_ACK: begin
                    // Commit only once the ACK clock completes, so an aborted byte never writes.
                    if (scl_fall) begin
                        state_d   = ST_WDATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        ptr_d     = ptr_q + 8'd1;
                        if (ptr_q == REG_SYS_CONFIG) begin
                            sys_config_d = shift_q;
                            wr_pulse_d   = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA_ACK;
                        sda_oe_d  = 1'b0;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RDATA_ACK: begin
                    // shift_q[0] holds the master's ACK (0) or NACK (1) sampled on the 9th rise.
                    if (scl_rise) begin
                        shift_d = shift_in;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d  = ST_RDATA;
                            ptr_d    = ptr_q + 8'd1;
                            shift_d  = next_byte;
                            sda_oe_d = ~next_byte[7];
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and register file; async reset releases sda immediately.
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            ptr_q        <= 8'h00;
            rw_q         <= 1'b0;
            shadow_q     <= 16'h0000;
            sys_config_q <= 8'h00;
            sda_oe_q     <= 1'b0;
            wr_pulse_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            shadow_q     <= shadow_d;
            sys_config_q <= sys_config_d;
            sda_oe_q     <= sda_oe_d;
            wr_pulse_q   <= wr_pulse_d;
            busy_q       <= busy_d;
        end
    end

    assign sda          = sda_oe_q ? 1'b0 : 1'bz;
    assign O_sys_config = sys_config_q;
    assign O_wr_pulse   = wr_pulse_q;
    assign O_busy       = busy_q;

endmodule

// File: tb/tb_ap3216_i2c_responder.sv
// tb/tb_ap3216_i2c_responder.sv - directed bus-master bench for the AP3216 I2C responder
module tb_ap3216_i2c_responder;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [15:0] als = 16'h0000;
    logic [7:0]  cfg;
    logic        wr_pulse;
    logic        busy;
    wire         sda;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [7:0] cfg_at_pulse = 8'h00;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    ap3216_i2c_responder dut (
        .I_clk       (clk),
        .I_reset     (rst_n),
        .scl         (m_scl),
        .sda         (sda),
        .I_als_data  (als),
        .O_sys_config(cfg),
        .O_wr_pulse  (wr_pulse),
        .O_busy      (busy)
    );

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            pulse_cnt    = pulse_cnt + 1;
            cfg_at_pulse = cfg;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i];
            wait_clk(Q);
            m_scl = 1'b1;
            wait_clk(Q);
            m_scl = 1'b0;
            wait_clk(Q);
        end
        m_sda_low = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q / 2);
        ack = sda;
        wait_clk(Q / 2);
        m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            m_scl = 1'b1;
            wait_clk(Q / 2);
            b[i] = sda;
            wait_clk(Q / 2);
            m_scl = 1'b0;
            wait_clk(Q);
        end
        m_sda_low = master_ack;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(Q);
        m_sda_low = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         p0;

        // Reset values
        wait_clk(5);
        check("reset_cfg", {8'h00, cfg}, 16'h0000);
        check("reset_pulse", {15'd0, wr_pulse}, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0000);
        check("reset_sda", {15'd0, sda}, 16'h0001);
        rst_n = 1'b1;
        wait_clk(5);

        // Write SYS_CONFIG = 0x01
        p0 = pulse_cnt;
        i2c_start();
        send_byte(8'h3C, ack); check("wr1_addr_ack", {15'd0, ack}, 16'h0000);
        check("wr1_busy", {15'd0, busy}, 16'h0001);
        send_byte(8'h00, ack); check("wr1_ptr_ack", {15'd0, ack}, 16'h0000);
        send_byte(8'h01, ack); check("wr1_data_ack", {15'd0, ack}, 16'h0000);
        i2c_stop();
        wait_clk(5);
        check("wr1_cfg", {8'h00, cfg}, 16'h0001);
        check("wr1_pulses", 16'(pulse_cnt - p0), 16'd1);
        check("wr1_cfg_at_pulse", {8'h00, cfg_at_pulse}, 16'h0001);
        check("wr1_busy_after_stop", {15'd0, busy}, 16'h0000);

        // Read ALS with ALS enabled; the shadow holds across a mid-read change
        als = 16'hA5C3;
        i2c_start();
        send_byte(8'h3C, ack); check("rd1_addr_ack", {15'd0, ack}, 16'h0000);
        send_byte(8'h0C, ack); check("rd1_ptr_ack", {15'd0, ack}, 16'h0000);
        i2c_start();
        send_byte(8'h3D, ack); check("rd1_raddr_ack", {15'd0, ack}, 16'h0000);
        read_byte(1'b1, rd); check("rd1_als_l", {8'h00, rd}, 16'h00C3);
        als = 16'h1234;
        read_byte(1'b0, rd); check("rd1_als_h", {8'h00, rd}, 16'h00A5);
        i2c_stop();

        // Disable ALS, then the same read returns zeros
        p0 = pulse_cnt;
        i2c_start();
        send_byte(8'h3C, ack);
        send_byte(8'h00, ack);
        send_byte(8'h00, ack); check("wr2_data_ack", {15'd0, ack}, 16'h0000);
        i2c_stop();
        wait_clk(5);
        check("wr2_cfg", {8'h00, cfg}, 16'h0000);
        check("wr2_pulses", 16'(pulse_cnt - p0), 16'd1);
        i2c_start();
        send_byte(8'h3C, ack);
        send_byte(8'h0C, ack);
        i2c_start();
        send_byte(8'h3D, ack);
        read_byte(1'b1, rd); check("rd2_als_l_off", {8'h00, rd}, 16'h0000);
        read_byte(1'b0, rd); check("rd2_als_h_off", {8'h00, rd}, 16'h0000);
        i2c_stop();

        // Wrong address is NACKed and ignored
        p0 = pulse_cnt;
        i2c_start();
        send_byte(8'h3E, ack); check("bad_addr_nack", {15'd0, ack}, 16'h0001);
        check("bad_addr_busy", {15'd0, busy}, 16'h0000);
        send_byte(8'h00, ack); check("bad_addr_ptr_nack", {15'd0, ack}, 16'h0001);
        i2c_stop();
        wait_clk(5);
        check("bad_addr_pulses", 16'(pulse_cnt - p0), 16'd0);

        // Pointer wrap 0xFF -> 0x00: second byte lands in SYS_CONFIG
        p0 = pulse_cnt;
        i2c_start();
        send_byte(8'h3C, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h55, ack); check("wrap_b1_ack", {15'd0, ack}, 16'h0000);
        send_byte(8'h81, ack); check("wrap_b2_ack", {15'd0, ack}, 16'h0000);
        i2c_stop();
        wait_clk(5);
        check("wrap_cfg", {8'h00, cfg}, 16'h0081);
        check("wrap_pulses", 16'(pulse_cnt - p0), 16'd1);

        // Async reset while the responder drives a 0 data bit
        i2c_start();
        send_byte(8'h3C, ack);
        send_byte(8'h05, ack);
        i2c_start();
        send_byte(8'h3D, ack); check("rst_raddr_ack", {15'd0, ack}, 16'h0000);
        check("rst_sda_driven_low", {15'd0, sda}, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_sda_released", {15'd0, sda}, 16'h0001);
        wait_clk(3);
        check("rst_cfg", {8'h00, cfg}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'h0000);
        rst_n = 1'b1;
        wait_clk(5);

        // Full write after reset recovery
        p0 = pulse_cnt;
        i2c_start();
        send_byte(8'h3C, ack); check("post_addr_ack", {15'd0, ack}, 16'h0000);
        send_byte(8'h00, ack); check("post_ptr_ack", {15'd0, ack}, 16'h0000);
        send_byte(8'h07, ack); check("post_data_ack", {15'd0, ack}, 16'h0000);
        i2c_stop();
        wait_clk(5);
        check("post_cfg", {8'h00, cfg}, 16'h0007);
        check("post_pulses", 16'(pulse_cnt - p0), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
